// File: rtl/muxn_hs_pkg.sv
// rtl/muxn_hs_pkg.sv - shared select-mode constants and rotating-priority pick helper
package muxn_hs_pkg;

    localparam logic MODE_STATIC = 1'b0;
    localparam logic MODE_RR     = 1'b1;

    // Widest channel count the helper supports; callers zero-extend narrower vectors.
    localparam int RR_MAX_N = 32;
    localparam int RR_IDX_W = 5;

    // Scan valid starting at ptr, wrapping at n, and return the first hit as one-hot.
    function automatic logic [RR_MAX_N-1:0] rr_pick(
        input logic [RR_MAX_N-1:0] valid,
        input int                  ptr,
        input int                  n
    );
        logic [RR_MAX_N-1:0] grant;
        logic                found;
        int                  idx;
        grant = '0;
        found = 1'b0;
        for (int k = 0; k < RR_MAX_N; k++) begin
            if (k < n) begin
                idx = ptr + k;
                if (idx >= n) begin
                    idx = idx - n;
                end
                if (!found && valid[idx[RR_IDX_W-1:0]]) begin
                    grant[idx[RR_IDX_W-1:0]] = 1'b1;
                    found = 1'b1;
                end
            end
        end
        return grant;
    endfunction

endpackage

// File: rtl/muxn_hs_module_rr_arbiter.sv
// rtl/muxn_hs_module_rr_arbiter.sv - combinational N-way rotating-priority arbiter
module rr_arbiter_module
    import muxn_hs_pkg::*;
#(
    parameter  int N     = 4,
    localparam int SEL_W = $clog2(N)
) (
    input  logic [N-1:0]     valid,
    input  logic [SEL_W-1:0] ptr,
    output logic [N-1:0]     grant
);

    logic [RR_MAX_N-1:0] w_valid_ext;
    logic [RR_MAX_N-1:0] w_grant_ext;

    always_comb begin
        w_valid_ext = '0;
        for (int i = 0; i < N; i++) begin
            w_valid_ext[i] = valid[i];
        end
        w_grant_ext = rr_pick(w_valid_ext, int'(ptr), N);
        grant = '0;
        for (int i = 0; i < N; i++) begin
            grant[i] = w_grant_ext[i];
        end
    end

endmodule

// File: rtl/muxn_hs_module.sv
// rtl/muxn_hs_module.sv - N-channel W-bit handshake mux with registered output
module muxn_hs_module
    import muxn_hs_pkg::*;
#(
    parameter  int N     = 4,
    parameter  int W     = 8,
    localparam int SEL_W = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             mode,
    input  logic [SEL_W-1:0] sel,
    input  logic [N*W-1:0]   in_data,
    input  logic [N-1:0]     in_valid,
    output logic [N-1:0]     in_ready,
    output logic [W-1:0]     out_data,
    output logic [SEL_W-1:0] out_chan,
    output logic             out_valid,
    input  logic             out_ready
);

    logic [W-1:0]     r_out_data;
    logic [SEL_W-1:0] r_out_chan;
    logic             r_out_valid;
    logic [SEL_W-1:0] r_rr_ptr;

    logic             w_load_en;
    logic [N-1:0]     w_rr_grant;
    logic [N-1:0]     w_static_grant;
    logic [N-1:0]     w_grant;
    logic [N-1:0]     w_xfer;
    logic             w_any_xfer;
    logic [SEL_W-1:0] w_idx;
    logic [W-1:0]     w_sel_data;

    rr_arbiter_module #(.N(N)) u_rr_arbiter (
        .valid (in_valid),
        .ptr   (r_rr_ptr),
        .grant (w_rr_grant)
    );

    assign w_load_en = !r_out_valid || out_ready;

    // A select beyond N-1 matches no channel, so nothing is granted.
    always_comb begin
        w_static_grant = '0;
        for (int i = 0; i < N; i++) begin
            w_static_grant[i] = (int'(sel) == i);
        end
    end

    assign w_grant    = (mode == MODE_RR) ? w_rr_grant : w_static_grant;
    assign in_ready   = rst_n ? (w_grant & {N{w_load_en}}) : '0;
    assign w_xfer     = in_valid & in_ready;
    assign w_any_xfer = |w_xfer;

    always_comb begin
        w_idx      = '0;
        w_sel_data = '0;
        for (int i = 0; i < N; i++) begin
            if (w_xfer[i]) begin
                w_idx      = SEL_W'(i);
                w_sel_data = in_data[i*W +: W];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_data  <= '0;
            r_out_chan  <= '0;
            r_out_valid <= 1'b0;
            r_rr_ptr    <= '0;
        end else if (w_any_xfer) begin
            r_out_data  <= w_sel_data;
            r_out_chan  <= w_idx;
            r_out_valid <= 1'b1;
            if (mode == MODE_RR) begin
                r_rr_ptr <= (w_idx == SEL_W'(N - 1)) ? '0 : w_idx + SEL_W'(1);
            end
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_data  = r_out_data;
    assign out_chan  = r_out_chan;
    assign out_valid = r_out_valid;

endmodule

// File: tb/tb_muxn_hs_module.sv
// tb/tb_muxn_hs_module.sv - scoreboard bench for muxn_hs_module
module tb_muxn_hs_module;

    logic        clk;
    logic        rst_n;
    logic        mode;
    logic [1:0]  sel;
    logic [31:0] in_data;
    logic [3:0]  in_valid;
    logic [3:0]  in_ready;
    logic [7:0]  out_data;
    logic [1:0]  out_chan;
    logic        out_valid;
    logic        out_ready;

    logic        mode3;
    logic [1:0]  sel3;
    logic [23:0] in_data3;
    logic [2:0]  in_valid3;
    logic [2:0]  in_ready3;
    logic [7:0]  out_data3;
    logic [1:0]  out_chan3;
    logic        out_valid3;
    logic        out_ready3;

    int errors = 0;
    int checks = 0;
    logic [9:0] exp_q[$];

    muxn_hs_module #(.N(4), .W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mode      (mode),
        .sel       (sel),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_chan  (out_chan),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    muxn_hs_module #(.N(3), .W(8)) dut3 (
        .clk       (clk),
        .rst_n     (rst_n),
        .mode      (mode3),
        .sel       (sel3),
        .in_data   (in_data3),
        .in_valid  (in_valid3),
        .in_ready  (in_ready3),
        .out_data  (out_data3),
        .out_chan  (out_chan3),
        .out_valid (out_valid3),
        .out_ready (out_ready3)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every output handshake pops one expected {data, chan} entry.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_out: got data %0h chan %0d expected no word", out_data, out_chan);
            end else begin
                logic [9:0] e;
                e = exp_q.pop_front();
                check("out_data", 32'(out_data), 32'(e[9:2]));
                check("out_chan", 32'(out_chan), 32'(e[1:0]));
            end
        end
    end

    initial begin
        rst_n = 1'b0; mode = 1'b0; sel = 2'd2; in_data = '0; in_valid = '0; out_ready = 1'b1;
        mode3 = 1'b0; sel3 = 2'd3; in_data3 = 24'h332211; in_valid3 = 3'b111; out_ready3 = 1'b1;
        repeat (3) step();
        check("rst_in_ready", 32'(in_ready), 32'h0);
        check("rst_out_valid", 32'(out_valid), 32'h0);
        check("rst_out_data", 32'(out_data), 32'h0);
        check("rst_out_chan", 32'(out_chan), 32'h0);

        // 1: static select of ch2
        rst_n = 1'b1; in_data = 32'h00A50000; in_valid = 4'b0100;
        exp_q.push_back({8'hA5, 2'd2});
        #2 check("t1_in_ready", 32'(in_ready), 32'h4);
        step();
        in_valid = 4'b0000;
        #2 check("t1_out_valid", 32'(out_valid), 32'h1);
        step();
        #2 check("t1_drained", 32'(out_valid), 32'h0);

        // 2: output stall on ch0
        sel = 2'd0; in_data = 32'h00000011; in_valid = 4'b0001; out_ready = 1'b0;
        exp_q.push_back({8'h11, 2'd0});
        step();
        for (int k = 0; k < 3; k++) begin
            #2;
            check("t2_stall_data", 32'(out_data), 32'h11);
            check("t2_stall_valid", 32'(out_valid), 32'h1);
            check("t2_stall_ready", 32'(in_ready), 32'h0);
            step();
        end
        in_data = 32'h00000022; out_ready = 1'b1;
        exp_q.push_back({8'h22, 2'd0});
        #2 check("t2_reload_ready", 32'(in_ready), 32'h1);
        step();
        in_valid = 4'b0000;
        #2 check("t2_reload_data", 32'(out_data), 32'h22);
        step();

        // 3: round-robin over four valid channels, wrapping back to ch0
        mode = 1'b1; in_data = 32'h40302010; in_valid = 4'b1111;
        exp_q.push_back({8'h10, 2'd0});
        exp_q.push_back({8'h20, 2'd1});
        exp_q.push_back({8'h30, 2'd2});
        exp_q.push_back({8'h40, 2'd3});
        exp_q.push_back({8'h10, 2'd0});
        for (int k = 0; k < 5; k++) begin
            logic [3:0] g;
            g = 4'b0001 << (k % 4);
            #2 check("t3_rr_grant", 32'(in_ready), 32'(g));
            step();
        end

        // 4: pointer at 1 with only ch0/ch3 valid picks ch3, then ch0
        in_valid = 4'b1001;
        exp_q.push_back({8'h40, 2'd3});
        #2 check("t4_grant_ch3", 32'(in_ready), 32'h8);
        step();
        exp_q.push_back({8'h10, 2'd0});
        #2 check("t4_grant_ch0", 32'(in_ready), 32'h1);
        step();
        in_valid = 4'b0000;
        step();

        // 5: N=3 with sel=3 grants nothing
        check("t5_oob_ready", 32'(in_ready3), 32'h0);
        check("t5_oob_valid", 32'(out_valid3), 32'h0);
        sel3 = 2'd1;
        #2 check("t5_sel1_ready", 32'(in_ready3), 32'h2);
        step();
        #2 check("t5_sel1_data", 32'(out_data3), 32'h22);
        sel3 = 2'd3;
        step();

        // 6: asynchronous reset while holding 0x5A
        mode = 1'b0; sel = 2'd1; in_data = 32'h00005A00; in_valid = 4'b0010; out_ready = 1'b0;
        step();
        in_valid = 4'b0000;
        #2;
        check("t6_held_valid", 32'(out_valid), 32'h1);
        check("t6_held_data", 32'(out_data), 32'h5A);
        rst_n = 1'b0;
        #1;
        check("t6_rst_valid", 32'(out_valid), 32'h0);
        check("t6_rst_data", 32'(out_data), 32'h0);
        check("t6_rst_chan", 32'(out_chan), 32'h0);
        check("t6_rst_ready", 32'(in_ready), 32'h0);
        step();
        rst_n = 1'b1; mode = 1'b1; in_data = 32'h40302010; in_valid = 4'b1111; out_ready = 1'b1;
        exp_q.push_back({8'h10, 2'd0});
        #2 check("t6_rr_restart", 32'(in_ready), 32'h1);
        step();
        in_valid = 4'b0000;
        repeat (2) step();

        check("queue_empty", 32'(exp_q.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
